// File: rtl/icu_wide.sv
// icu_wide: one-instruction-per-clock control unit with WIDTH-bit result
// register, input/output enables, registered output latch and a
// single-slot skip mechanism for RTN and SKZ.

package instructions;
    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;
endpackage

module icu_wide #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          data_in,
    input  instructions::instruction_t i,
    output logic                      write,
    output logic [WIDTH-1:0]          data_out,
    output logic                      jmp,
    output logic                      rtn,
    output logic                      flag_o,
    output logic                      flag_f,
    output logic [WIDTH-1:0]          rr_out
);
    import instructions::*;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_SKIP = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_rr;
    logic [WIDTH-1:0] r_dout;
    logic             r_ien;
    logic             r_oen;
    logic             r_write;
    logic             r_jmp;
    logic             r_rtn;
    logic             r_flag_o;
    logic             r_flag_f;
    logic [WIDTH-1:0] w_d;

    // Effective operand: input bus gated by the input-enable register
    always_comb begin
        w_d = r_ien ? data_in : '0;
    end

    // Execute one instruction per edge; a skipped slot only clears the skip
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_rr     <= '0;
            r_dout   <= '0;
            r_ien    <= 1'b0;
            r_oen    <= 1'b0;
            r_write  <= 1'b0;
            r_jmp    <= 1'b0;
            r_rtn    <= 1'b0;
            r_flag_o <= 1'b0;
            r_flag_f <= 1'b0;
        end else begin
            r_write  <= 1'b0;
            r_jmp    <= 1'b0;
            r_rtn    <= 1'b0;
            r_flag_o <= 1'b0;
            r_flag_f <= 1'b0;
            if (r_state == ST_SKIP) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_RUN;
                case (i)
                    NOPO: r_flag_o <= 1'b1;
                    LD:   r_rr <= w_d;
                    LDC:  r_rr <= ~w_d;
                    AND:  r_rr <= r_rr & w_d;
                    ANDC: r_rr <= r_rr & ~w_d;
                    OR:   r_rr <= r_rr | w_d;
                    ORC:  r_rr <= r_rr | ~w_d;
                    XNOR: r_rr <= ~(r_rr ^ w_d);
                    STO: begin
                        if (r_oen) begin
                            r_dout  <= r_rr;
                            r_write <= 1'b1;
                        end
                    end
                    STOC: begin
                        if (r_oen) begin
                            r_dout  <= ~r_rr;
                            r_write <= 1'b1;
                        end
                    end
                    IEN:  r_ien <= data_in[0];
                    OEN:  r_oen <= data_in[0];
                    JMP:  r_jmp <= 1'b1;
                    RTN: begin
                        r_rtn   <= 1'b1;
                        r_state <= ST_SKIP;
                    end
                    SKZ: begin
                        if (r_rr == '0) r_state <= ST_SKIP;
                    end
                    NOPF: r_flag_f <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign write    = r_write;
    assign data_out = r_dout;
    assign jmp      = r_jmp;
    assign rtn      = r_rtn;
    assign flag_o   = r_flag_o;
    assign flag_f   = r_flag_f;
    assign rr_out   = r_rr;

endmodule

// File: tb/tb_icu_wide.sv
// tb_icu_wide: directed scenarios plus randomized instruction streams for
// icu_wide (WIDTH=8), checked against a behavioural model of the machine.

module tb_icu_wide;
    import instructions::*;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    instruction_t i;
    logic         write;
    logic [W-1:0] data_out;
    logic         jmp;
    logic         rtn;
    logic         flag_o;
    logic         flag_f;
    logic [W-1:0] rr_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference machine state
    logic [W-1:0] m_rr, m_dout;
    bit           m_ien, m_oen, m_skip;
    bit           m_write, m_jmp, m_rtn, m_fo, m_ff;

    icu_wide #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .i        (i),
        .write    (write),
        .data_out (data_out),
        .jmp      (jmp),
        .rtn      (rtn),
        .flag_o   (flag_o),
        .flag_f   (flag_f),
        .rr_out   (rr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the reference by one clock edge with the given inputs
    task automatic model_step(input bit r, input instruction_t op, input logic [W-1:0] din);
        logic [W-1:0] d;
        m_write = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
        if (r) begin
            m_rr = '0; m_dout = '0; m_ien = 0; m_oen = 0; m_skip = 0;
        end else if (m_skip) begin
            m_skip = 0;
        end else begin
            d = m_ien ? din : '0;
            case (op)
                NOPO: m_fo = 1;
                NOPF: m_ff = 1;
                JMP:  m_jmp = 1;
                RTN:  begin m_rtn = 1; m_skip = 1; end
                SKZ:  m_skip = (m_rr == 0);
                LD:   m_rr = d;
                LDC:  m_rr = ~d;
                AND:  m_rr = m_rr & d;
                ANDC: m_rr = m_rr & ~d;
                OR:   m_rr = m_rr | d;
                ORC:  m_rr = m_rr | ~d;
                XNOR: m_rr = ~(m_rr ^ d);
                STO:  if (m_oen) begin m_dout = m_rr;  m_write = 1; end
                STOC: if (m_oen) begin m_dout = ~m_rr; m_write = 1; end
                IEN:  m_ien = din[0];
                OEN:  m_oen = din[0];
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".rr"},     32'(rr_out),   32'(m_rr));
        check({tag, ".dout"},   32'(data_out), 32'(m_dout));
        check({tag, ".write"},  32'(write),    32'(m_write));
        check({tag, ".jmp"},    32'(jmp),      32'(m_jmp));
        check({tag, ".rtn"},    32'(rtn),      32'(m_rtn));
        check({tag, ".flag_o"}, 32'(flag_o),   32'(m_fo));
        check({tag, ".flag_f"}, 32'(flag_f),   32'(m_ff));
    endtask

    // Apply one cycle, then compare every output against the model
    task automatic step(input bit r, input instruction_t op, input logic [W-1:0] din, input string tag);
        rst = r; i = op; data_in = din;
        @(posedge clk);
        #1;
        model_step(r, op, din);
        compare_all(tag);
    endtask

    initial begin
        rst = 1'b1; i = NOPO; data_in = '0;

        // Reset, with an instruction presented that must be ignored
        step(1, JMP, 8'hFF, "rst");
        check("rst_rr", 32'(rr_out), 32'h0);
        check("rst_jmp", 32'(jmp), 32'h0);

        // Load path with enables
        step(0, IEN, 8'h01, "ien1");
        step(0, OEN, 8'h01, "oen1");
        step(0, LD,  8'hA5, "ldA5");
        check("ldA5_abs", 32'(rr_out), 32'hA5);
        check("ldA5_wr", 32'(write), 32'h0);

        // Logic ops and complemented store
        step(0, ORC,  8'hF0, "orc");
        check("orc_abs", 32'(rr_out), 32'hAF);
        step(0, XNOR, 8'h0F, "xnor");
        check("xnor_abs", 32'(rr_out), 32'h5F);
        step(0, STOC, 8'h00, "stoc");
        check("stoc_dout", 32'(data_out), 32'hA0);
        check("stoc_wr", 32'(write), 32'h1);
        step(0, NOPO, 8'h00, "after_stoc");
        check("wr_one_cycle", 32'(write), 32'h0);

        // Output disabled, input disabled
        step(0, OEN, 8'h00, "oen0");
        step(0, STO, 8'h00, "sto_dis");
        check("sto_dis_dout", 32'(data_out), 32'hA0);
        step(0, IEN, 8'h00, "ien0");
        step(0, LD,  8'hFF, "ld_gated");
        check("ld_gated_abs", 32'(rr_out), 32'h00);

        // SKZ with RR zero skips the next LD
        step(0, IEN, 8'h01, "ien1b");
        step(0, SKZ, 8'h00, "skz");
        step(0, LD,  8'hFF, "ld_skipped");
        check("ld_skipped_abs", 32'(rr_out), 32'h00);
        step(0, LD,  8'hFF, "ld_exec");
        check("ld_exec_abs", 32'(rr_out), 32'hFF);

        // SKZ with RR non-zero does nothing
        step(0, LD,  8'h80, "ld80");
        step(0, SKZ, 8'h00, "skz_nz");
        step(0, LD,  8'h11, "ld_after_nz");
        check("skz_nz_abs", 32'(rr_out), 32'h11);

        // RTN pulses and skips the following NOPF; skipped SKZ does not re-arm
        step(0, RTN,  8'h00, "rtn");
        check("rtn_abs", 32'(rtn), 32'h1);
        step(0, NOPF, 8'h00, "nopf_skipped");
        check("nopf_skipped_abs", 32'(flag_f), 32'h0);
        step(0, NOPO, 8'h00, "nopo");
        check("nopo_abs", 32'(flag_o), 32'h1);
        step(0, RTN,  8'h00, "rtn2");
        step(0, SKZ,  8'h00, "skz_skipped");
        step(0, LD,   8'h22, "ld_after_skipped_skz");
        check("no_rearm_abs", 32'(rr_out), 32'h22);

        // Back-to-back pulses hold high
        step(0, JMP, 8'h00, "jmp_a");
        step(0, JMP, 8'h00, "jmp_b");
        check("jmp_hold", 32'(jmp), 32'h1);

        // Reset overrides a pending skip
        step(0, LD,  8'h00, "ld0");
        step(0, SKZ, 8'h00, "skz_pre_rst");
        step(1, NOPF, 8'h00, "rst_in_skip");
        check("rst_in_skip_rr", 32'(rr_out), 32'h0);
        step(0, IEN, 8'h01, "ien_post_rst");
        step(0, LD,  8'h3C, "ld3C");
        check("ld3C_abs", 32'(rr_out), 32'h3C);

        // Randomized instruction stream, occasional reset
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 99) == 0), instruction_t'($urandom_range(0, 15)),
                 W'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
